// File: rtl/afe_spi_master.sv
// afe_spi_master: full-duplex SPI master for N_DEV AFE devices, MSB-first DATA_W-bit words.
// Define AFE_SPI_READBACK_EN to build the MISO capture path; otherwise rsp_data is tied to zero.
module afe_spi_master #(
    parameter int  DATA_W  = 24,
    parameter int  N_DEV   = 4,
    parameter int  CLK_DIV = 4,
    localparam int SEL_W   = $clog2(N_DEV)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [SEL_W-1:0]  cmd_dev,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              spi_clk_o,
    output logic              spi_mosi_o,
    input  logic              spi_miso_i,
    output logic              spi_sel,
    output logic [SEL_W-1:0]  sel_o
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [SEL_W:0]   DEV_LIMIT = (SEL_W + 1)'(N_DEV);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_LATCH, S_HOLD, S_ERR
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic              phase_q, phase_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-2:0] tx_q, tx_d;
    logic              mosi_q, mosi_d;
    logic              sclk_q, sclk_d;
    logic              ssel_q, ssel_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              ready_q, ready_d;
    logic              rvalid_q, rvalid_d;
    logic              rerr_q, rerr_d;
    logic              sample_en;
    logic              rsp_ok;

    // Handshake: a command transfers on a sys_clk edge where cmd_valid & cmd_ready are both high;
    // cmd_ready is only ever high in IDLE, so a requester must hold cmd_valid/cmd_data until then.
    logic tick, accept, dev_ok;
    assign tick   = (hcnt_q == '0);
    assign accept = cmd_valid & ready_q;
    assign dev_ok = ({1'b0, cmd_dev} < DEV_LIMIT);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = dev_ok ? S_SETUP : S_ERR;
            S_SETUP: if (tick) state_d = S_SHIFT;
            S_SHIFT: if (tick && phase_q && bit_q == '0) state_d = S_LATCH;
            S_LATCH: if (tick) state_d = S_HOLD;
            S_HOLD:  if (tick) state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hcnt_d    = hcnt_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        mosi_d    = mosi_q;
        sclk_d    = sclk_q;
        ssel_d    = ssel_q;
        sel_d     = sel_q;
        rvalid_d  = 1'b0;
        rerr_d    = rerr_q;
        sample_en = 1'b0;
        rsp_ok    = 1'b0;
        ready_d   = (state_q == S_IDLE) && !accept;
        case (state_q)
            S_IDLE: begin
                hcnt_d = '0;
                if (accept && dev_ok) begin
                    hcnt_d  = HALF_LAST;
                    tx_d    = cmd_data[DATA_W-2:0];
                    mosi_d  = cmd_data[DATA_W-1];
                    sel_d   = cmd_dev;
                    bit_d   = BIT_LAST;
                    phase_d = 1'b0;
                    sclk_d  = 1'b0;
                end
            end
            S_SETUP: hcnt_d = tick ? HALF_LAST : hcnt_q - 1'b1;
            S_SHIFT: begin
                hcnt_d = tick ? HALF_LAST : hcnt_q - 1'b1;
                if (tick) begin
                    if (!phase_q) begin
                        // Rising SPI edge: capture MISO on the same sys_clk edge.
                        sclk_d    = 1'b1;
                        phase_d   = 1'b1;
                        sample_en = 1'b1;
                    end else begin
                        sclk_d  = 1'b0;
                        phase_d = 1'b0;
                        if (bit_q == '0) begin
                            ssel_d = 1'b1;
                        end else begin
                            bit_d  = bit_q - 1'b1;
                            mosi_d = tx_q[DATA_W-2];
                            tx_d   = {tx_q[DATA_W-3:0], 1'b0};
                        end
                    end
                end
            end
            S_LATCH: begin
                hcnt_d = tick ? HALF_LAST : hcnt_q - 1'b1;
                if (tick) ssel_d = 1'b0;
            end
            S_HOLD: begin
                if (tick) begin
                    hcnt_d   = '0;
                    sel_d    = '0;
                    mosi_d   = 1'b0;
                    rvalid_d = 1'b1;
                    rerr_d   = 1'b0;
                    rsp_ok   = 1'b1;
                end else begin
                    hcnt_d = hcnt_q - 1'b1;
                end
            end
            S_ERR: begin
                hcnt_d   = '0;
                rvalid_d = 1'b1;
                rerr_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hcnt_q   <= '0;
            phase_q  <= 1'b0;
            bit_q    <= '0;
            tx_q     <= '0;
            mosi_q   <= 1'b0;
            sclk_q   <= 1'b0;
            ssel_q   <= 1'b0;
            sel_q    <= '0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            hcnt_q   <= hcnt_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            mosi_q   <= mosi_d;
            sclk_q   <= sclk_d;
            ssel_q   <= ssel_d;
            sel_q    <= sel_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
        end
    end

`ifdef AFE_SPI_READBACK_EN
    logic [DATA_W-1:0] cap_q, cap_d, rdata_q, rdata_d;

    always_comb begin
        cap_d   = cap_q;
        rdata_d = rdata_q;
        if (sample_en) cap_d = {cap_q[DATA_W-2:0], spi_miso_i};
        if (rsp_ok) rdata_d = cap_q;
        if (state_q == S_ERR) rdata_d = '0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cap_q   <= '0;
            rdata_q <= '0;
        end else begin
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
        end
    end

    assign rsp_data = rdata_q;
`else
    logic unused_readback;
    assign unused_readback = ^{spi_miso_i, sample_en, rsp_ok};
    assign rsp_data        = '0;
`endif

    assign cmd_ready  = ready_q;
    assign rsp_valid  = rvalid_q;
    assign rsp_err    = rerr_q;
    assign busy       = (state_q != S_IDLE);
    assign spi_clk_o  = sclk_q;
    assign spi_mosi_o = mosi_q;
    assign spi_sel    = ssel_q;
    assign sel_o      = sel_q;

endmodule

// File: tb/tb_afe_spi_master.sv
// Bench for afe_spi_master: default instance plus a DATA_W=8 / N_DEV=3 / CLK_DIV=2 instance.
module tb_afe_spi_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef AFE_SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic m_valid, m_ready, m_rv, m_rerr, m_busy, m_sclk, m_mosi, m_miso, m_ssel;
  logic [23:0] m_data, m_rdata;
  logic [1:0] m_dev, m_sel;
  logic s_valid, s_ready, s_rv, s_rerr, s_busy, s_sclk, s_mosi, s_miso, s_ssel;
  logic [7:0] s_data, s_rdata;
  logic [1:0] s_dev, s_sel;

  bit loop_en;
  logic miso_drv;
  assign m_miso = loop_en ? m_mosi : miso_drv;
  assign s_miso = loop_en ? s_mosi : miso_drv;

  afe_spi_master u_main (
    .sys_clk(clk), .sys_rst_n(rst_n), .cmd_valid(m_valid), .cmd_ready(m_ready),
    .cmd_data(m_data), .cmd_dev(m_dev), .rsp_valid(m_rv), .rsp_data(m_rdata),
    .rsp_err(m_rerr), .busy(m_busy), .spi_clk_o(m_sclk), .spi_mosi_o(m_mosi),
    .spi_miso_i(m_miso), .spi_sel(m_ssel), .sel_o(m_sel)
  );

  afe_spi_master #(.DATA_W(8), .N_DEV(3), .CLK_DIV(2)) u_small (
    .sys_clk(clk), .sys_rst_n(rst_n), .cmd_valid(s_valid), .cmd_ready(s_ready),
    .cmd_data(s_data), .cmd_dev(s_dev), .rsp_valid(s_rv), .rsp_data(s_rdata),
    .rsp_err(s_rerr), .busy(s_busy), .spi_clk_o(s_sclk), .spi_mosi_o(s_mosi),
    .spi_miso_i(s_miso), .spi_sel(s_ssel), .sel_o(s_sel)
  );

  // Monitor view of whichever instance the current transfer targets.
  bit tgt;
  logic v_ready, v_rv, v_rerr, v_sclk, v_mosi, v_ssel;
  logic [1:0] v_sel;
  logic [23:0] v_rdata;
  always_comb begin
    if (tgt) begin
      v_ready = s_ready; v_rv = s_rv; v_rerr = s_rerr; v_sclk = s_sclk;
      v_mosi = s_mosi; v_ssel = s_ssel; v_sel = s_sel; v_rdata = {16'h0, s_rdata};
    end else begin
      v_ready = m_ready; v_rv = m_rv; v_rerr = m_rerr; v_sclk = m_sclk;
      v_mosi = m_mosi; v_ssel = m_ssel; v_sel = m_sel; v_rdata = m_rdata;
    end
  end

  int n_checks, n_pass;

  // Driver + observer for one transfer; lat counts edges from acceptance to the edge sampling rsp_valid.
  task automatic xfer(input bit sm, input logic [23:0] d, input logic [1:0] dev,
                      input logic [1:0] sel_exp, input logic [23:0] mw,
                      output int lat, output int rises, output logic [23:0] mosi_w,
                      output int sel_bad, output int strobe_cyc, output int strobe_pulses,
                      output int ready_bad, output logic [23:0] rdata, output logic rerr,
                      output logic rv_after, output logic [23:0] rdata_after, output bit tmo);
    int w, k, wait_n;
    logic prev_sclk, prev_ssel;
    w = sm ? 8 : 24;
    tgt = sm;
    lat = 0; rises = 0; mosi_w = '0; sel_bad = 0; strobe_cyc = 0; strobe_pulses = 0;
    ready_bad = 0; rdata = '0; rerr = 1'b0; rv_after = 1'b0; rdata_after = '0; tmo = 1'b1;
    miso_drv = mw[w-1];
    @(negedge clk);
    wait_n = 0;
    while (!v_ready && wait_n < 50) begin @(negedge clk); wait_n++; end
    if (!v_ready) return;
    if (sm) begin s_valid = 1'b1; s_data = d[7:0]; s_dev = dev; end
    else begin m_valid = 1'b1; m_data = d; m_dev = dev; end
    @(negedge clk);
    m_valid = 1'b0; s_valid = 1'b0;
    prev_sclk = 1'b0; prev_ssel = 1'b0; k = 0;
    while (k < 1000) begin
      if (v_rv) begin lat = k + 1; rdata = v_rdata; rerr = v_rerr; tmo = 1'b0; break; end
      if (v_sel !== sel_exp) sel_bad++;
      if (v_ready) ready_bad++;
      if (v_sclk && !prev_sclk) begin
        mosi_w = {mosi_w[22:0], v_mosi};
        rises++;
        if (rises < w) miso_drv = mw[w-1-rises];
      end
      if (v_ssel) strobe_cyc++;
      if (v_ssel && !prev_ssel) strobe_pulses++;
      prev_sclk = v_sclk; prev_ssel = v_ssel;
      @(negedge clk); k++;
    end
    if (!tmo) begin @(negedge clk); rv_after = v_rv; rdata_after = v_rdata; end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({m_ready, m_busy, m_rv, m_rerr, m_sclk, m_mosi, m_ssel, m_sel} !== '0)
      $display("FAIL reset_main_ctrl: got %b expected 0", {m_ready, m_busy, m_rv, m_rerr, m_sclk, m_mosi, m_ssel, m_sel}); else n_pass++;
    n_checks++; if (m_rdata !== 24'h0) $display("FAIL reset_main_rdata: got %h expected 0", m_rdata); else n_pass++;
    n_checks++; if ({s_ready, s_busy, s_rv, s_rerr, s_sclk, s_mosi, s_ssel, s_sel, s_rdata} !== '0)
      $display("FAIL reset_small: got %h expected 0", {s_ready, s_busy, s_rv, s_rerr, s_sclk, s_mosi, s_ssel, s_sel, s_rdata}); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++; if ({m_ready, s_ready} !== 2'b00) $display("FAIL ready_before_edge: got %b expected 00", {m_ready, s_ready}); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if ({m_ready, s_ready} !== 2'b11) $display("FAIL ready_after_edge: got %b expected 11", {m_ready, s_ready}); else n_pass++;
  endtask

  task automatic test_vector();
    int lat, rises, sel_bad, sc, sp, rb;
    logic [23:0] mosi_w, rdata, rda;
    logic rerr, rva;
    bit tmo;
    logic [23:0] exp_rd;
    loop_en = 1'b1;
    exp_rd = RB ? 24'hA5C3F0 : 24'h0;
    xfer(1'b0, 24'hA5C3F0, 2'd2, 2'd2, 24'h0, lat, rises, mosi_w, sel_bad, sc, sp, rb, rdata, rerr, rva, rda, tmo);
    n_checks++; if (tmo !== 1'b0) $display("FAIL vec_timeout: no rsp_valid within bound"); else n_pass++;
    n_checks++; if (lat !== 205) $display("FAIL vec_latency: got %0d expected 205", lat); else n_pass++;
    n_checks++; if (rises !== 24) $display("FAIL vec_rises: got %0d expected 24", rises); else n_pass++;
    n_checks++; if (mosi_w !== 24'hA5C3F0) $display("FAIL vec_mosi: got %h expected a5c3f0", mosi_w); else n_pass++;
    n_checks++; if (sel_bad !== 0) $display("FAIL vec_sel: %0d cycles with sel_o != 2", sel_bad); else n_pass++;
    n_checks++; if (sc !== 4 || sp !== 1) $display("FAIL vec_strobe: got %0d cycles %0d pulses expected 4 and 1", sc, sp); else n_pass++;
    n_checks++; if (rb !== 0) $display("FAIL vec_ready_busy: cmd_ready high %0d busy cycles expected 0", rb); else n_pass++;
    n_checks++; if (rdata !== exp_rd || rerr !== 1'b0) $display("FAIL vec_rsp: got %h err %b expected %h err 0", rdata, rerr, exp_rd); else n_pass++;
    n_checks++; if (rva !== 1'b0 || rda !== exp_rd) $display("FAIL vec_rsp_hold: valid %b data %h expected 0 and %h", rva, rda, exp_rd); else n_pass++;
  endtask

  task automatic test_random();
    int lat, rises, sel_bad, sc, sp, rb;
    logic [23:0] mosi_w, rdata, rda, d, mw;
    logic [1:0] dev;
    logic rerr, rva;
    bit tmo;
    loop_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = 24'($urandom()); mw = 24'($urandom()); dev = 2'($urandom_range(0, 3));
      xfer(1'b0, d, dev, dev, mw, lat, rises, mosi_w, sel_bad, sc, sp, rb, rdata, rerr, rva, rda, tmo);
      n_checks++; if (tmo || lat !== 205) $display("FAIL rnd_latency[%0d]: got %0d expected 205", i, lat); else n_pass++;
      n_checks++; if (mosi_w !== d) $display("FAIL rnd_mosi[%0d]: got %h expected %h", i, mosi_w, d); else n_pass++;
      n_checks++; if (rdata !== (RB ? mw : 24'h0)) $display("FAIL rnd_rdata[%0d]: got %h expected %h", i, rdata, RB ? mw : 24'h0); else n_pass++;
      n_checks++; if (sel_bad !== 0 || sc !== 4) $display("FAIL rnd_sel[%0d]: sel_bad %0d strobe %0d expected 0 and 4", i, sel_bad, sc); else n_pass++;
    end
  endtask

  task automatic test_small_readback();
    int lat, rises, sel_bad, sc, sp, rb;
    logic [23:0] mosi_w, rdata, rda, d;
    logic rerr, rva;
    bit tmo;
    loop_en = 1'b0;
    d = {16'h0, 8'($urandom())};
    xfer(1'b1, d, 2'd1, 2'd1, 24'h3C, lat, rises, mosi_w, sel_bad, sc, sp, rb, rdata, rerr, rva, rda, tmo);
    n_checks++; if (tmo || lat !== 39) $display("FAIL small_latency: got %0d expected 39", lat); else n_pass++;
    n_checks++; if (rdata !== (RB ? 24'h3C : 24'h0) || rerr !== 1'b0) $display("FAIL small_rdata: got %h err %b expected %h err 0", rdata, rerr, RB ? 24'h3C : 24'h0); else n_pass++;
    n_checks++; if (rises !== 8 || mosi_w[7:0] !== d[7:0]) $display("FAIL small_mosi: rises %0d word %h expected 8 and %h", rises, mosi_w[7:0], d[7:0]); else n_pass++;
    n_checks++; if (sc !== 2 || sel_bad !== 0) $display("FAIL small_strobe: strobe %0d sel_bad %0d expected 2 and 0", sc, sel_bad); else n_pass++;
  endtask

  task automatic test_err();
    int lat, rises, sel_bad, sc, sp, rb;
    logic [23:0] mosi_w, rdata, rda;
    logic rerr, rva;
    bit tmo;
    xfer(1'b1, 24'h5A, 2'd3, 2'd0, 24'hFF, lat, rises, mosi_w, sel_bad, sc, sp, rb, rdata, rerr, rva, rda, tmo);
    n_checks++; if (tmo || lat !== 2) $display("FAIL err_latency: got %0d expected 2", lat); else n_pass++;
    n_checks++; if (rerr !== 1'b1 || rdata !== 24'h0) $display("FAIL err_rsp: err %b data %h expected 1 and 0", rerr, rdata); else n_pass++;
    n_checks++; if (rises !== 0 || sc !== 0 || sel_bad !== 0) $display("FAIL err_pins: rises %0d strobe %0d sel %0d expected 0", rises, sc, sel_bad); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int acc_pos[$];
    int rsp_pos[$];
    logic [23:0] exp_q[$];
    logic [23:0] cmds[3];
    logic [23:0] e;
    int idx;
    bit adv;
    loop_en = 1'b1; tgt = 1'b0;
    for (int i = 0; i < 3; i++) cmds[i] = 24'($urandom());
    m_dev = 2'($urandom_range(0, 3));
    @(negedge clk);
    m_valid = 1'b1; m_data = cmds[0]; idx = 0; adv = 1'b0;
    for (int n = 0; n < 2000 && rsp_pos.size() < 3; n++) begin
      if (adv) begin
        idx++;
        if (idx < 3) m_data = cmds[idx]; else m_valid = 1'b0;
        adv = 1'b0;
      end
      if (m_rv) begin
        rsp_pos.push_back(n);
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL b2b_rsp: unexpected rsp_valid data %h", m_rdata);
        else begin
          e = exp_q.pop_front();
          if (m_rdata !== e) $display("FAIL b2b_rsp: got %h expected %h", m_rdata, e); else n_pass++;
        end
      end
      if (m_valid && m_ready) begin
        acc_pos.push_back(n + 1);
        exp_q.push_back(RB ? m_data : 24'h0);
        adv = 1'b1;
      end
      @(negedge clk);
    end
    m_valid = 1'b0;
    n_checks++; if (acc_pos.size() !== 3 || rsp_pos.size() !== 3) $display("FAIL b2b_count: acc %0d rsp %0d expected 3 and 3", acc_pos.size(), rsp_pos.size()); else n_pass++;
    for (int i = 0; i < acc_pos.size() && i < rsp_pos.size(); i++) begin
      n_checks++; if (rsp_pos[i] - acc_pos[i] + 1 !== 205) $display("FAIL b2b_latency[%0d]: got %0d expected 205", i, rsp_pos[i] - acc_pos[i] + 1); else n_pass++;
      if (i > 0) begin
        n_checks++; if (acc_pos[i] !== rsp_pos[i-1] + 2) $display("FAIL b2b_gap[%0d]: accept at %0d expected %0d", i, acc_pos[i], rsp_pos[i-1] + 2); else n_pass++;
      end
    end
  endtask

  task automatic test_busy_pulses();
    int extra_acc, rsp_cnt;
    loop_en = 1'b0; miso_drv = 1'b0; tgt = 1'b0;
    @(negedge clk);
    m_valid = 1'b1; m_data = 24'($urandom()); m_dev = 2'd1;
    @(negedge clk);
    m_valid = 1'b0; extra_acc = 0; rsp_cnt = 0;
    for (int n = 0; n < 150; n++) begin
      m_valid = 1'($urandom_range(0, 1)); m_data = 24'($urandom()); m_dev = 2'($urandom_range(0, 3));
      @(negedge clk);
      if (m_valid && m_ready) extra_acc++;
      if (m_rv) rsp_cnt++;
    end
    m_valid = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (m_rv) rsp_cnt++;
    end
    n_checks++; if (extra_acc !== 0) $display("FAIL busy_ignored: %0d acceptances while busy expected 0", extra_acc); else n_pass++;
    n_checks++; if (rsp_cnt !== 1 || m_busy !== 1'b0) $display("FAIL busy_rsp: %0d responses busy %b expected 1 and 0", rsp_cnt, m_busy); else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    int rises, rv_cnt;
    logic prev_sclk;
    bit found;
    loop_en = 1'b0; miso_drv = 1'b1; tgt = 1'b0;
    @(negedge clk);
    m_valid = 1'b1; m_data = 24'($urandom()); m_dev = 2'd3;
    @(negedge clk);
    m_valid = 1'b0; rises = 0; prev_sclk = 1'b0; found = 1'b0;
    for (int n = 0; n < 1000 && !found; n++) begin
      if (m_sclk && !prev_sclk) rises++;
      prev_sclk = m_sclk;
      if (rises == 11 && m_sclk) found = 1'b1; else @(negedge clk);
    end
    n_checks++; if (!found || m_sel !== 2'd3) $display("FAIL mid_reach_bit10: found %b sel %0d expected 1 and 3", found, m_sel); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({m_sclk, m_ssel, m_sel, m_mosi, m_busy, m_ready, m_rv} !== '0)
      $display("FAIL mid_async_reset: got %b expected 0", {m_sclk, m_ssel, m_sel, m_mosi, m_busy, m_ready, m_rv}); else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (m_ready !== 1'b0) $display("FAIL mid_ready_release: got %b expected 0", m_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (m_ready !== 1'b1) $display("FAIL mid_ready_after: got %b expected 1", m_ready); else n_pass++;
    rv_cnt = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (m_rv) rv_cnt++;
    end
    n_checks++; if (rv_cnt !== 0 || m_rdata !== 24'h0) $display("FAIL mid_no_rsp: %0d responses data %h expected 0", rv_cnt, m_rdata); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_pass = 0;
    m_valid = 1'b0; m_data = '0; m_dev = '0;
    s_valid = 1'b0; s_data = '0; s_dev = '0;
    loop_en = 1'b0; miso_drv = 1'b0; tgt = 1'b0;
    test_reset();
    test_vector();
    test_random();
    test_small_readback();
    test_err();
    test_back_to_back();
    test_busy_pulses();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
